// File: rtl/mem_port_arbiter.sv
// Two-master round-robin arbiter in front of a single-port, registered-read word memory.
// Each transfer takes one ACCESS cycle (strobe) and one DONE cycle (Rdy + read data).
module mem_port_arbiter #(
  parameter int unsigned AW        = 32,
  parameter int unsigned DW        = 32,
  parameter int unsigned FIRST_GNT = 0
) (
  input  logic          iClk,
  input  logic          nRst,
  input  logic [AW-1:0] iP0Addr,
  input  logic [DW-1:0] iP0Data,
  input  logic          iP0Read,
  input  logic          iP0Write,
  output logic [DW-1:0] oP0Data,
  output logic          oP0Rdy,
  input  logic [AW-1:0] iP1Addr,
  input  logic [DW-1:0] iP1Data,
  input  logic          iP1Read,
  input  logic          iP1Write,
  output logic [DW-1:0] oP1Data,
  output logic          oP1Rdy,
  output logic [AW-1:0] oMemAddr,
  output logic [DW-1:0] oMemData,
  output logic          oMemRead,
  output logic          oMemWrite,
  input  logic [DW-1:0] iMemData,
  output logic [1:0]    oGnt
);

  typedef enum logic [1:0] {StIdle, StAccess, StDone} state_e;

  // Pointer reset value makes FIRST_GNT the winner of the first tie.
  localparam logic LastRst = (FIRST_GNT == 0);

  state_e        state_q, state_d;
  logic [1:0]    gnt_q, gnt_d;
  logic          last_q, last_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic          wr_q, wr_d;
  logic [DW-1:0] p0_data_q, p0_data_d;
  logic [DW-1:0] p1_data_q, p1_data_d;

  logic p0_req, p1_req;
  logic grant_now, sel;

  assign p0_req = iP0Read | iP0Write;
  assign p1_req = iP1Read | iP1Write;

  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    last_d    = last_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    wr_d      = wr_q;
    p0_data_d = p0_data_q;
    p1_data_d = p1_data_q;
    grant_now = 1'b0;
    sel       = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (p0_req && p1_req) begin
          grant_now = 1'b1;
          sel       = ~last_q;
        end else if (p0_req || p1_req) begin
          grant_now = 1'b1;
          sel       = p1_req;
        end
      end
      StAccess: state_d = StDone;
      StDone: begin
        last_d = gnt_q[1];
        if (gnt_q[1]) p1_data_d = iMemData;
        else          p0_data_d = iMemData;
        // The finishing master still holds its request; only the other one may take over.
        if (gnt_q[0] && p1_req) begin
          grant_now = 1'b1;
          sel       = 1'b1;
        end else if (gnt_q[1] && p0_req) begin
          grant_now = 1'b1;
          sel       = 1'b0;
        end else begin
          state_d = StIdle;
          gnt_d   = 2'b00;
        end
      end
      default: begin
        state_d = StIdle;
        gnt_d   = 2'b00;
      end
    endcase

    if (grant_now) begin
      state_d = StAccess;
      gnt_d   = sel ? 2'b10 : 2'b01;
      addr_d  = sel ? iP1Addr : iP0Addr;
      wdata_d = sel ? iP1Data : iP0Data;
      wr_d    = sel ? iP1Write : iP0Write;
    end
  end

  always_ff @(posedge iClk or negedge nRst) begin
    if (!nRst) begin
      state_q   <= StIdle;
      gnt_q     <= 2'b00;
      last_q    <= LastRst;
      addr_q    <= '0;
      wdata_q   <= '0;
      wr_q      <= 1'b0;
      p0_data_q <= '0;
      p1_data_q <= '0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      last_q    <= last_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      wr_q      <= wr_d;
      p0_data_q <= p0_data_d;
      p1_data_q <= p1_data_d;
    end
  end

  // Strobes decode straight from the state so an async reset drops them at once.
  assign oMemAddr  = addr_q;
  assign oMemData  = wdata_q;
  assign oMemRead  = (state_q == StAccess) && !wr_q;
  assign oMemWrite = (state_q == StAccess) && wr_q;
  assign oGnt      = gnt_q;
  assign oP0Rdy    = (state_q == StDone) && gnt_q[0];
  assign oP1Rdy    = (state_q == StDone) && gnt_q[1];
  assign oP0Data   = oP0Rdy ? iMemData : p0_data_q;
  assign oP1Data   = oP1Rdy ? iMemData : p1_data_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomised bench for mem_port_arbiter: a timeline model predicts strobe/Rdy cycles,
// owner and returned data from the round-robin rules and a reference memory image.
module tb_mem_port_arbiter;
  localparam int AW       = 32;
  localparam int DW       = 32;
  localparam int FirstGnt = 0;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [AW-1:0] iP0Addr, iP1Addr, oMemAddr;
  logic [DW-1:0] iP0Data, iP1Data, oP0Data, oP1Data, oMemData;
  logic          iP0Read, iP0Write, iP1Read, iP1Write;
  logic          oP0Rdy, oP1Rdy, oMemRead, oMemWrite;
  logic [DW-1:0] iMemData;
  logic [1:0]    oGnt;

  always #5 clk = ~clk;

  mem_port_arbiter #(.AW(AW), .DW(DW), .FIRST_GNT(FirstGnt)) dut (
    .iClk(clk), .nRst(rst_n),
    .iP0Addr(iP0Addr), .iP0Data(iP0Data), .iP0Read(iP0Read), .iP0Write(iP0Write),
    .oP0Data(oP0Data), .oP0Rdy(oP0Rdy),
    .iP1Addr(iP1Addr), .iP1Data(iP1Data), .iP1Read(iP1Read), .iP1Write(iP1Write),
    .oP1Data(oP1Data), .oP1Rdy(oP1Rdy),
    .oMemAddr(oMemAddr), .oMemData(oMemData), .oMemRead(oMemRead), .oMemWrite(oMemWrite),
    .iMemData(iMemData), .oGnt(oGnt)
  );

  // Registered-read memory; 16 words indexed by address bits [5:2].
  logic [31:0] mem [16];
  logic        mem_ld = 1'b0;
  logic [3:0]  mem_ld_idx = '0;
  logic [31:0] mem_ld_val = '0;
  always @(posedge clk) begin
    if (mem_ld) mem[mem_ld_idx] <= mem_ld_val;
    else if (oMemWrite) mem[oMemAddr[5:2]] <= oMemData;
    iMemData <= mem[oMemAddr[5:2]];
  end

  // Master drivers: mode 0 random, 1 continuous reads, 2 idle (manual requests only).
  logic        rd [2];
  logic        wr [2];
  logic [31:0] adr [2];
  logic [31:0] dat [2];
  int          mode [2];
  int          waitc [2];
  int          rdy_cnt [2];
  logic        man_v [2];
  logic        man_wr [2];
  logic [31:0] man_adr [2];
  logic [31:0] man_dat [2];

  assign iP0Read  = rd[0];
  assign iP0Write = wr[0];
  assign iP0Addr  = adr[0];
  assign iP0Data  = dat[0];
  assign iP1Read  = rd[1];
  assign iP1Write = wr[1];
  assign iP1Addr  = adr[1];
  assign iP1Data  = dat[1];

  // Reference model: at most one transfer in flight, described by its scheduled cycles.
  logic [31:0] ref_mem [16];
  logic [31:0] pdat [2];
  bit          tv;
  int          own, last, strobe_at, rdy_at, cyc;
  bit          twr;
  logic [31:0] taddr, tdata, trdata;
  bit          hold_rst;
  logic        mw_seen;

  int checks = 0;
  int fails  = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic new_req(input int m, input bit rd_only);
    logic [31:0] a;
    int k;
    a = $urandom;
    a[1:0] = 2'b00;
    k = rd_only ? 0 : int'($urandom_range(0, 3));
    rd[m]  = (k <= 1) || (k == 3);
    wr[m]  = (k >= 2);
    adr[m] = a;
    dat[m] = $urandom;
  endtask

  task automatic queue_req(input int m, input logic w, input logic [31:0] a, input logic [31:0] d);
    man_v[m]   = 1'b1;
    man_wr[m]  = w;
    man_adr[m] = a;
    man_dat[m] = d;
  endtask

  task automatic model_reset();
    tv   = 1'b0;
    last = (FirstGnt == 0) ? 1 : 0;
    pdat[0] = '0;
    pdat[1] = '0;
  endtask

  task automatic model_decide();
    bit c0, c1, done_now;
    int g;
    done_now = tv && (cyc == rdy_at);
    if (tv && !done_now) return;
    c0 = rd[0] | wr[0];
    c1 = rd[1] | wr[1];
    if (done_now) begin
      last = own;
      tv   = 1'b0;
      if (own == 0) c0 = 1'b0;
      else          c1 = 1'b0;
    end
    if (c0 && c1)  g = (last == 0) ? 1 : 0;
    else if (c0)   g = 0;
    else if (c1)   g = 1;
    else           g = -1;
    if (g >= 0) begin
      tv        = 1'b1;
      own       = g;
      twr       = wr[g];
      taddr     = adr[g];
      tdata     = dat[g];
      strobe_at = cyc + 1;
      rdy_at    = cyc + 2;
    end
  endtask

  task automatic drive(input int m, input logic got_rdy);
    if (!rst_n) waitc[m] = 0;
    if (rd[m] | wr[m]) begin
      if (got_rdy) begin
        rd[m] = 1'b0;
        wr[m] = 1'b0;
        waitc[m] = 0;
        rdy_cnt[m]++;
        if (mode[m] == 1) new_req(m, 1'b1);
        else if (mode[m] == 0 && $urandom_range(0, 1) == 1) new_req(m, 1'b0);
      end else if (rst_n) begin
        waitc[m]++;
        if (waitc[m] > 40) begin
          check_eq("req_timeout", 32'(waitc[m]), 32'd0);
          rd[m] = 1'b0;
          wr[m] = 1'b0;
          waitc[m] = 0;
        end
      end
    end else if (man_v[m]) begin
      man_v[m] = 1'b0;
      rd[m]  = !man_wr[m];
      wr[m]  = man_wr[m];
      adr[m] = man_adr[m];
      dat[m] = man_dat[m];
    end else if (mode[m] == 0 && $urandom_range(0, 2) == 0) begin
      new_req(m, 1'b0);
    end else if (mode[m] == 1) begin
      new_req(m, 1'b1);
    end
  endtask

  task automatic step();
    logic exp_rd, exp_wr, exp_r0, exp_r1, got_r0, got_r1;
    logic [1:0] exp_g;
    @(negedge clk);
    cyc++;
    if (!rst_n) model_reset();
    exp_rd = tv && (cyc == strobe_at) && !twr;
    exp_wr = tv && (cyc == strobe_at) && twr;
    if (tv && cyc == strobe_at) begin
      check_eq("mem_addr", oMemAddr, taddr);
      if (twr) check_eq("mem_wdata", oMemData, tdata);
      trdata = ref_mem[taddr[5:2]];
    end
    exp_g  = !tv ? 2'b00 : ((own == 1) ? 2'b10 : 2'b01);
    exp_r0 = tv && (cyc == rdy_at) && (own == 0);
    exp_r1 = tv && (cyc == rdy_at) && (own == 1);
    if (tv && cyc == rdy_at) begin
      pdat[own] = trdata;
      if (twr) ref_mem[taddr[5:2]] = tdata;
    end
    check_eq("mem_read", 32'(oMemRead), 32'(exp_rd));
    check_eq("mem_write", 32'(oMemWrite), 32'(exp_wr));
    check_eq("gnt", 32'(oGnt), 32'(exp_g));
    check_eq("p0_rdy", 32'(oP0Rdy), 32'(exp_r0));
    check_eq("p1_rdy", 32'(oP1Rdy), 32'(exp_r1));
    check_eq("p0_data", oP0Data, pdat[0]);
    check_eq("p1_data", oP1Data, pdat[1]);
    if (!rst_n) begin
      check_eq("rst_mem_addr", oMemAddr, 32'd0);
      check_eq("rst_mem_wdata", oMemData, 32'd0);
    end
    got_r0  = oP0Rdy;
    got_r1  = oP1Rdy;
    mw_seen = oMemWrite;
    drive(0, got_r0);
    drive(1, got_r1);
    rst_n = !hold_rst;
    if (rst_n) model_decide();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic wait_rdy(input int m, input string tag);
    int c0;
    c0 = rdy_cnt[m];
    for (int i = 0; i < 20 && rdy_cnt[m] == c0; i++) step();
    check_eq(tag, 32'(rdy_cnt[m] - c0), 32'd1);
  endtask

  task automatic load_word(input int idx, input logic [31:0] v);
    mem_ld     = 1'b1;
    mem_ld_idx = 4'(idx);
    mem_ld_val = v;
    ref_mem[idx] = v;
    step();
    mem_ld = 1'b0;
  endtask

  initial begin
    int b0, b1;
    cyc = 0;
    hold_rst = 1'b1;
    for (int m = 0; m < 2; m++) begin
      mode[m] = 1; waitc[m] = 0; rdy_cnt[m] = 0; man_v[m] = 1'b0;
      man_wr[m] = 1'b0; man_adr[m] = '0; man_dat[m] = '0;
      new_req(m, 1'b1);
    end
    model_reset();

    // Both masters request while in reset; everything must stay at zero.
    for (int i = 0; i < 16; i++) load_word(i, $urandom);
    load_word(4, 32'hDEADBEEF);

    // Release into continuous contention: strict alternation starting at FIRST_GNT.
    hold_rst = 1'b0;
    b0 = rdy_cnt[0];
    step();
    step();
    check_eq("first_gnt_strobe", 32'(oGnt), 32'd1);
    step();
    check_eq("first_gnt_rdy", 32'(rdy_cnt[0] - b0), 32'd1);
    run(20);
    check_eq("alternation_balance", 32'((rdy_cnt[0] - rdy_cnt[1]) inside {-1, 0, 1}), 32'd1);
    mode[0] = 2;
    mode[1] = 2;
    run(6);

    // Single read and single write/readback.
    queue_req(0, 1'b0, 32'h10, 32'h0);
    wait_rdy(0, "single_read_done");
    check_eq("single_read_data", oP0Data, 32'hDEADBEEF);
    queue_req(1, 1'b1, 32'h20, 32'h12345678);
    wait_rdy(1, "single_write_done");
    queue_req(1, 1'b0, 32'h20, 32'h0);
    wait_rdy(1, "readback_done");
    check_eq("readback_data", oP1Data, 32'h12345678);

    // m0 streams reads; m1's pending write must be served by the second slot.
    mode[0] = 1;
    b0 = rdy_cnt[0];
    queue_req(1, 1'b1, 32'h24, 32'hCAFEF00D);
    wait_rdy(1, "starve_m1_done");
    check_eq("starve_m1_slot", 32'((rdy_cnt[0] - b0) <= 1), 32'd1);
    b1 = rdy_cnt[0];
    run(8);
    check_eq("starve_m0_continues", 32'((rdy_cnt[0] - b1) >= 3), 32'd1);
    mode[0] = 2;
    run(6);

    // Async reset during the ACCESS cycle of a write.
    load_word(12, 32'hAAAA5555);
    queue_req(1, 1'b1, 32'h30, 32'h11112222);
    mw_seen = 1'b0;
    for (int i = 0; i < 8 && !mw_seen; i++) step();
    check_eq("abort_write_seen", 32'(mw_seen), 32'd1);
    #2;
    hold_rst = 1'b1;
    rst_n = 1'b0;
    #1;
    check_eq("abort_write_drop", 32'(oMemWrite), 32'd0);
    check_eq("abort_gnt", 32'(oGnt), 32'd0);
    check_eq("abort_rdy", 32'(oP1Rdy), 32'd0);
    rd[1] = 1'b0;
    wr[1] = 1'b0;
    run(3);
    check_eq("abort_mem_kept", mem[12], 32'hAAAA5555);
    hold_rst = 1'b0;
    queue_req(0, 1'b0, 32'h30, 32'h0);
    queue_req(1, 1'b0, 32'h30, 32'h0);
    b0 = rdy_cnt[0];
    run(3);
    check_eq("restart_first_gnt", 32'(rdy_cnt[0] - b0), 32'd1);
    wait_rdy(1, "restart_m1_done");
    check_eq("restart_m1_data", oP1Data, 32'hAAAA5555);

    // Random traffic from both masters.
    mode[0] = 0;
    mode[1] = 0;
    run(500);
    mode[0] = 2;
    mode[1] = 2;
    run(10);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Two-master arbiter sharing the single-port, registered-read word memory between the Processor (port 0) and a secondary master (port 1), such as a program loader, DMA or debug port.
- Sits between the masters' memory buses and the memory model/RAM.
- Generates each master's ready (iMemRdy-style) handshake and multiplexes address, data and strobes.
- Round-robin arbitration with back-to-back hand-over; no master can be starved.

Parameters:
AW, 32, address width (byte address; passed through untouched)
DW, 32, data width
FIRST_GNT, 0, master that wins a simultaneous request on the first arbitration after reset (0 or 1)

Ports:
iClk  in  1  system clock, all state changes on rising edge
nRst  in  1  asynchronous active-low reset
iP0Addr  in  AW  master 0 byte address
iP0Data  in  DW  master 0 write data
iP0Read  in  1  master 0 read request, held until oP0Rdy
iP0Write  in  1  master 0 write request, held until oP0Rdy
oP0Data  out  DW  master 0 read data, valid when oP0Rdy=1
oP0Rdy  out  1  master 0 transfer-complete pulse
iP1Addr, iP1Data, iP1Read, iP1Write, oP1Data, oP1Rdy  as master 0, for master 1
oMemAddr  out  AW  memory byte address
oMemData  out  DW  memory write data
oMemRead  out  1  memory read strobe
oMemWrite  out  1  memory write strobe
iMemData  in  DW  memory read data, registered by memory (1-cycle latency)
oGnt  out  2  one-hot current owner, {m1,m0}; 00 when idle

Behaviour:
- Reset (async, nRst=0):
  - state=IDLE, oMemRead=oMemWrite=0, oP0Rdy=oP1Rdy=0, oGnt=00.
  - oMemAddr, oMemData, oP0Data and oP1Data all 0.
  - Last-granted pointer set so that FIRST_GNT wins the next tie.
  - Reset mid-ACCESS drops the strobes immediately; the aborted transfer never produces Rdy.
- States: IDLE, ACCESS, DONE.
- IDLE:
  - Requester m is pending if iPmRead|iPmWrite.
  - One pending: grant it. Both pending: grant the one not last granted.
  - On grant, latch addr, wdata and op (write if iPmWrite, else read) into registers; go to ACCESS and set oGnt.
- ACCESS (exactly 1 cycle):
  - oMemAddr/oMemData are driven from the latched registers.
  - oMemWrite=1 for a write op; oMemRead=1 for a read op.
  - Next state DONE.
- DONE (exactly 1 cycle):
  - Strobes 0. oPmRdy=1 for the granted master only. oPmData=iMemData for both reads and writes.
  - The other master's Rdy stays 0 and its Data holds its previous value.
  - Update the last-granted pointer.
  - If the other master is pending: grant it directly (DONE->ACCESS, zero idle cycles). Otherwise go to IDLE.
  - The current master's request is ignored in DONE because it is still holding its completed request.
- Latency: request sampled in IDLE at cycle 0, strobe in cycle 1, Rdy in cycle 2 (3 cycles from request to Rdy).
- Steady state, both masters continuously requesting: strict alternation, one transfer per 2 cycles.
- Masters must hold addr/data/op stable until Rdy. Dropping a request after grant does not cancel the transfer: it completes and Rdy still pulses.
- Read and write both asserted by one master: treated as a write. Returned data is the pre-write memory content.
- Rdy is a single-cycle pulse, never asserted on both ports in the same cycle.
- oGnt is one-hot during ACCESS/DONE and 00 in IDLE.
- Address and data are not modified; word alignment is the memory's concern.

Test Plan:
- Reset: hold nRst=0 with both masters requesting -> all outputs 0, oGnt=00; release -> FIRST_GNT=0 gives m0 the ACCESS strobe at the 1st edge after release, oP0Rdy at the 2nd.
- Single read: mem[0x10>>2]=0xDEADBEEF, m0 reads 0x10 -> oMemRead=1 for 1 cycle with oMemAddr=0x10, then oP0Rdy=1 with oP0Data=0xDEADBEEF; oP1Rdy stays 0.
- Single write: m1 writes 0x12345678 to 0x20, then reads 0x20 -> oMemWrite pulse with oMemData=0x12345678, oP1Rdy pulse, read returns 0x12345678.
- Contention: both masters request reads continuously after reset -> grant order m0,m1,m0,m1 with 2 cycles between successive Rdy pulses, no IDLE cycles, no double Rdy.
- Starvation check: m0 issues 8 back-to-back reads while m1 holds one write -> m1 completes by the 2nd grant slot; m0's requests then continue.
- Async reset mid-ACCESS on a write to 0x30 (old value 0xAAAA5555) -> oMemWrite drops immediately, no Rdy, mem[0x30>>2] still 0xAAAA5555; after release, arbitration restarts from the FIRST_GNT tie-break.
